// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sequencer
// Purpose  : Self-test sequencer for a 3-input, single-output logic block.
//            Holds a loadable table of ROWS entries {A,B,C,F}. On start it
//            applies each row's {A,B,C} to the block under test, waits SETTLE
//            cycles, compares the block's output with F and tallies results.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            tt_wr_en/addr/data  - table write port (ignored while busy)
//            start               - level-sampled run request (IDLE only)
//            dut_in / dut_f      - registered stimulus out, response in
//            busy / done         - run in progress / one-cycle end pulse
//            pass_count, fail_count, first_fail_valid, first_fail_row
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
  parameter int ROWS   = 16,  // table depth, 2..16
  parameter int SETTLE = 1    // wait cycles before sampling dut_f, 1..7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tt_wr_en,
  input  logic [3:0] tt_wr_addr,
  input  logic [3:0] tt_wr_data,
  input  logic       start,
  output logic [2:0] dut_in,
  input  logic       dut_f,
  output logic       busy,
  output logic       done,
  output logic [4:0] pass_count,
  output logic [4:0] fail_count,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_row
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_APPLY = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_CHECK = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  localparam logic [2:0] c_SETTLE_INIT = 3'(SETTLE);
  localparam logic [3:0] c_LAST_ROW    = 4'(ROWS - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [2:0] settle_q, settle_d;
  logic [2:0] dut_in_q, dut_in_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [4:0] pass_count_q, pass_count_d;
  logic [4:0] fail_count_q, fail_count_d;
  logic       ff_valid_q, ff_valid_d;
  logic [3:0] ff_row_q, ff_row_d;

  logic [3:0] table_q [ROWS];
  logic [3:0] row_entry;
  logic       wr_ok;

  // --------------------------------------------------------------------------
  // Table storage: not reset. Addresses at or above ROWS match no row and are
  // therefore dropped without any explicit range check.
  // --------------------------------------------------------------------------
  assign wr_ok = tt_wr_en && !busy_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (wr_ok && (tt_wr_addr == 4'(i))) begin
        table_q[i] <= tt_wr_data;
      end
    end
  end

  // Read mux for the current row
  always_comb begin
    row_entry = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_q == 4'(i)) begin
        row_entry = table_q[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= c_ST_IDLE;
      row_q        <= '0;
      settle_q     <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_count_q <= '0;
      fail_count_q <= '0;
      ff_valid_q   <= 1'b0;
      ff_row_q     <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      settle_q     <= settle_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
      ff_valid_q   <= ff_valid_d;
      ff_row_q     <= ff_row_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:  if (start) state_d = c_ST_APPLY;
      c_ST_APPLY: state_d = c_ST_WAIT;
      // The counter is loaded with SETTLE, so WAIT lasts exactly SETTLE cycles
      c_ST_WAIT:  if (settle_q == 3'd1) state_d = c_ST_CHECK;
      c_ST_CHECK: state_d = (row_q == c_LAST_ROW) ? c_ST_DONE : c_ST_APPLY;
      c_ST_DONE:  state_d = c_ST_IDLE;
      default:    state_d = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath / output next values
  // --------------------------------------------------------------------------
  always_comb begin
    row_d        = row_q;
    settle_d     = settle_q;
    dut_in_d     = dut_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;
    ff_valid_d   = ff_valid_q;
    ff_row_d     = ff_row_q;
    case (state_q)
      c_ST_IDLE: begin
        if (start) begin
          row_d        = '0;
          pass_count_d = '0;
          fail_count_d = '0;
          ff_valid_d   = 1'b0;
          ff_row_d     = '0;
          busy_d       = 1'b1;
        end
      end
      c_ST_APPLY: begin
        dut_in_d = row_entry[3:1];
        settle_d = c_SETTLE_INIT;
      end
      c_ST_WAIT: begin
        settle_d = settle_q - 3'd1;
      end
      c_ST_CHECK: begin
        if (dut_f == row_entry[0]) begin
          pass_count_d = pass_count_q + 5'd1;
        end else begin
          fail_count_d = fail_count_q + 5'd1;
          // Rows are walked in ascending order, so the first capture is the
          // lowest failing row.
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_row_d   = row_q;
          end
        end
        if (row_q != c_LAST_ROW) begin
          row_d = row_q + 4'd1;
        end
      end
      c_ST_DONE: begin
        // done rises as busy falls, so the two never overlap
        done_d   = 1'b1;
        busy_d   = 1'b0;
        dut_in_d = '0;
      end
      default: ;
    endcase
  end

  assign dut_in           = dut_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass_count       = pass_count_q;
  assign fail_count       = fail_count_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_row   = ff_row_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sequencer
// Purpose  : Directed self-checking bench. Instance A uses default parameters
//            with an XOR model (optionally faulted at {A,B,C}=101); instance B
//            uses ROWS=8, SETTLE=3 with an XOR model delayed by two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (ROWS=16, SETTLE=1) ----------------
  logic       rst_n_a, wr_en_a, start_a, fault_a;
  logic [3:0] wr_addr_a, wr_data_a;
  logic [2:0] dut_in_a;
  logic       dut_f_a, busy_a, done_a, ffv_a;
  logic [4:0] pass_a, fail_a;
  logic [3:0] ffr_a;

  assign dut_f_a = (^dut_in_a) ^ (fault_a && (dut_in_a == 3'b101));

  truth_table_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .tt_wr_en(wr_en_a), .tt_wr_addr(wr_addr_a),
    .tt_wr_data(wr_data_a), .start(start_a), .dut_in(dut_in_a), .dut_f(dut_f_a),
    .busy(busy_a), .done(done_a), .pass_count(pass_a), .fail_count(fail_a),
    .first_fail_valid(ffv_a), .first_fail_row(ffr_a)
  );

  // ---------------- instance B (ROWS=8, SETTLE=3) ----------------
  logic       rst_n_b, wr_en_b, start_b;
  logic [3:0] wr_addr_b, wr_data_b;
  logic [2:0] dut_in_b;
  logic       dut_f_b, busy_b, done_b, ffv_b;
  logic [4:0] pass_b, fail_b;
  logic [3:0] ffr_b;
  logic       d1_b, d2_b;

  always @(posedge clk) begin
    d1_b <= ^dut_in_b;
    d2_b <= d1_b;
  end
  assign dut_f_b = d2_b;

  truth_table_sequencer #(.ROWS(8), .SETTLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .tt_wr_en(wr_en_b), .tt_wr_addr(wr_addr_b),
    .tt_wr_data(wr_data_b), .start(start_b), .dut_in(dut_in_b), .dut_f(dut_f_b),
    .busy(busy_b), .done(done_b), .pass_count(pass_b), .fail_count(fail_b),
    .first_fail_valid(ffv_b), .first_fail_row(ffr_b)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [2:0] seen_a [16];
  int done_at, done_cnt, overlap, busy0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All tasks are entered right after a falling edge.
  task automatic wr_a(input logic [3:0] addr, input logic [3:0] data);
    wr_en_a = 1'b1; wr_addr_a = addr; wr_data_a = data;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [3:0] data);
    wr_en_b = 1'b1; wr_addr_b = addr; wr_data_b = data;
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  // One run on instance A. n counts falling edges after the edge that
  // accepts start (n=0). Row r's inputs are visible at n = 1 + 3r and done
  // is expected at n = 49.
  task automatic run_a(input bit mid, input bit wr_same,
                       input logic [3:0] w_addr, input logic [3:0] w_data);
    done_at = -1; done_cnt = 0; overlap = 0; busy0 = 0;
    for (int i = 0; i < 16; i++) seen_a[i] = 3'bxxx;
    start_a = 1'b1;
    if (wr_same) begin
      wr_en_a = 1'b1; wr_addr_a = w_addr; wr_data_a = w_data;
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start_a = 1'b0;
        wr_en_a = 1'b0;
        busy0 = int'(busy_a);
      end
      if (mid) begin
        if (n == 10 || n == 30) start_a = 1'b1;
        if (n == 11 || n == 31) start_a = 1'b0;
        if (n == 20) begin
          wr_en_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 4'hE;
        end
        if (n == 21) wr_en_a = 1'b0;
      end
      if (n >= 1 && ((n - 1) % 3) == 0 && ((n - 1) / 3) < 16)
        seen_a[(n - 1) / 3] = dut_in_a;
      if (done_a) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (done_a && busy_a) overlap++;
    end
  endtask

  initial begin
    rst_n_a = 1'b0; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    start_a = 1'b0; fault_a = 1'b0;
    rst_n_b = 1'b0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check_val("rst_busy",   int'(busy_a),   0);
    check_val("rst_done",   int'(done_a),   0);
    check_val("rst_dut_in", int'(dut_in_a), 0);
    check_val("rst_pass",   int'(pass_a),   0);
    check_val("rst_fail",   int'(fail_a),   0);
    check_val("rst_ffv",    int'(ffv_a),    0);
    check_val("rst_ffr",    int'(ffr_a),    0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    // ---- load XOR table: row i = {i[2:0], parity} ----
    for (int i = 0; i < 16; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      wr_a(4'(i), {abc, ^abc});
    end

    // ---- run 1: clean XOR ----
    run_a(1'b0, 1'b0, 4'd0, 4'd0);
    check_val("r1_busy_at_accept", busy0, 1);
    check_val("r1_done_at", done_at, 49);
    check_val("r1_done_cnt", done_cnt, 1);
    check_val("r1_overlap", overlap, 0);
    check_val("r1_pass", int'(pass_a), 16);
    check_val("r1_fail", int'(fail_a), 0);
    check_val("r1_ffv",  int'(ffv_a),  0);
    for (int i = 0; i < 16; i++)
      check_val($sformatf("r1_seq%0d", i), int'(seen_a[i]), i % 8);
    check_val("r1_dut_in_idle", int'(dut_in_a), 0);

    // ---- run 2: model wrong at 101 (rows 5 and 13) ----
    fault_a = 1'b1;
    run_a(1'b0, 1'b0, 4'd0, 4'd0);
    fault_a = 1'b0;
    check_val("r2_pass", int'(pass_a), 14);
    check_val("r2_fail", int'(fail_a), 2);
    check_val("r2_ffv",  int'(ffv_a),  1);
    check_val("r2_ffr",  int'(ffr_a),  5);

    // ---- run 3: stray starts and a write mid-run ----
    run_a(1'b1, 1'b0, 4'd0, 4'd0);
    check_val("r3_done_cnt", done_cnt, 1);
    check_val("r3_done_at",  done_at, 49);
    check_val("r3_pass", int'(pass_a), 16);
    check_val("r3_ffr_cleared", int'(ffr_a), 0);

    // ---- run 4: row 0 still original ----
    run_a(1'b0, 1'b0, 4'd0, 4'd0);
    check_val("r4_row0_in", int'(seen_a[0]), 0);
    check_val("r4_pass", int'(pass_a), 16);

    // ---- run 5: write row 4 in the start cycle ----
    run_a(1'b0, 1'b1, 4'd4, {3'b110, 1'b0});
    check_val("r5_row4_in", int'(seen_a[4]), 6);
    check_val("r5_row3_in", int'(seen_a[3]), 3);
    check_val("r5_pass", int'(pass_a), 16);
    wr_a(4'd4, {3'b100, 1'b1});

    // ---- reset while row 7 is in WAIT ----
    start_a = 1'b1;
    for (int n = 0; n < 23; n++) begin
      @(negedge clk);
      if (n == 0) start_a = 1'b0;
    end
    check_val("abort_pre_dut_in", int'(dut_in_a), 7);
    check_val("abort_pre_pass",   int'(pass_a),   7);
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    check_val("abort_busy",   int'(busy_a),   0);
    check_val("abort_dut_in", int'(dut_in_a), 0);
    check_val("abort_pass",   int'(pass_a),   0);
    check_val("abort_fail",   int'(fail_a),   0);
    check_val("abort_done",   int'(done_a),   0);
    @(negedge clk);

    // ---- run 6: table intact after reset ----
    run_a(1'b0, 1'b0, 4'd0, 4'd0);
    check_val("r6_done_at", done_at, 49);
    check_val("r6_pass", int'(pass_a), 16);
    check_val("r6_row4_in", int'(seen_a[4]), 4);
    check_val("r6_row15_in", int'(seen_a[15]), 7);

    // ---- instance B: ROWS=8, SETTLE=3, two-cycle DUT latency ----
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      wr_b(4'(i), {abc, ^abc});
    end
    wr_b(4'd8, 4'hF);  // out of range: must not alias onto row 0
    done_at = -1; done_cnt = 0;
    start_b = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (n == 0) start_b = 1'b0;
      if (done_b) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    check_val("b_done_at", done_at, 41);
    check_val("b_done_cnt", done_cnt, 1);
    check_val("b_pass", int'(pass_b), 8);
    check_val("b_fail", int'(fail_b), 0);
    check_val("b_ffv",  int'(ffv_b),  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
